// File: rtl/msb_sum_pipe_if.sv
// Operand/result channel between the MSB prefix network and msb_sum_pipe.
// master drives operands and out_ready; slave is the summing pipeline.
interface msb_sum_pipe_if;
  logic       in_valid;
  logic       in_ready;
  logic       cin;
  logic [7:0] px;
  logic [7:0] gx;
  logic       g_msb;
  logic [8:0] ref_sum;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       err_flag;
  logic [8:0] err_dist;

  modport master (
    output in_valid, cin, px, gx, g_msb, ref_sum, out_ready,
    input  in_ready, out_valid, sum, cout, err_flag, err_dist
  );

  modport slave (
    input  in_valid, cin, px, gx, g_msb, ref_sum, out_ready,
    output in_ready, out_valid, sum, cout, err_flag, err_dist
  );
endinterface

// File: rtl/msb_sum_pipe.sv
// Two-stage sum/carry-out pipeline for the MSB prefix network, with running
// error statistics against an exact reference sum.
module msb_sum_pipe #(
  parameter int CNT_W = 16,
  parameter int ACC_W = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  msb_sum_pipe_if.slave        bus,
  input  logic                 clr_stats,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [ACC_W-1:0]     ed_acc,
  output logic [8:0]           max_ed
);

  logic       s1_valid;
  logic [8:0] s1_res;
  logic [8:0] s1_ref;
  logic       s2_valid;
  logic       s1_adv;
  logic       accept;
  logic       out_hs;
  logic [8:0] calc_res;
  logic [8:0] calc_dist;
  logic [ACC_W:0] ed_sum;
  logic       unused_gx0;

  // gx[0] is the raw generate of bit 0; bit 0 of the sum takes cin instead.
  assign unused_gx0 = bus.gx[0];

  assign calc_res[0]   = bus.px[0] ^ bus.cin;
  assign calc_res[7:1] = bus.px[7:1] ^ bus.gx[7:1];
  assign calc_res[8]   = bus.g_msb | (bus.px[7] & bus.gx[7]);

  assign calc_dist = (s1_res >= s1_ref) ? (s1_res - s1_ref) : (s1_ref - s1_res);

  assign s1_adv       = s1_valid & (~s2_valid | bus.out_ready);
  assign bus.in_ready = ~s1_valid | s1_adv;
  assign accept       = bus.in_valid & bus.in_ready;
  assign out_hs       = s2_valid & bus.out_ready;
  assign bus.out_valid = s2_valid;

  assign ed_sum = {1'b0, ed_acc} + {{(ACC_W-8){1'b0}}, bus.err_dist};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_res   <= '0;
      s1_ref   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_res   <= calc_res;
      s1_ref   <= bus.ref_sum;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 data holds whenever the result is stalled, so outputs stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid     <= 1'b0;
      bus.sum      <= '0;
      bus.cout     <= 1'b0;
      bus.err_flag <= 1'b0;
      bus.err_dist <= '0;
    end else if (s1_adv) begin
      s2_valid     <= 1'b1;
      bus.sum      <= s1_res[7:0];
      bus.cout     <= s1_res[8];
      bus.err_flag <= (s1_res != s1_ref);
      bus.err_dist <= calc_dist;
    end else if (bus.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // Statistics count delivered results only; clearing wins over a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_acc     <= '0;
      max_ed     <= '0;
    end else if (clr_stats) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_acc     <= '0;
      max_ed     <= '0;
    end else if (out_hs) begin
      if (sample_cnt != '1)
        sample_cnt <= sample_cnt + CNT_W'(1);
      if (bus.err_flag && (err_cnt != '1))
        err_cnt <= err_cnt + CNT_W'(1);
      ed_acc <= ed_sum[ACC_W] ? '1 : ed_sum[ACC_W-1:0];
      if (bus.err_dist > max_ed)
        max_ed <= bus.err_dist;
    end
  end

endmodule
